// File: rtl/led_ctrl_pkg.sv
// Shared types and defaults for the LED update controller: FSM states,
// requester identities and the default LED word width.
package led_ctrl_pkg;

  localparam int DEF_DATA_BITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIRE,
    WAIT
  } state_e;

  typedef enum logic [1:0] {
    REQ_CPU,
    REQ_SW,
    REQ_REFRESH
  } req_id_e;

endpackage

// File: rtl/led_update_ctrl_if.sv
// Requester and shifter-side signal bundle for led_update_ctrl.
// slave  : the controller view.
// master : the surrounding logic (bus decode, switch mirror, P2S shifter).
interface led_update_ctrl_if #(
  parameter int DATA_BITS = led_ctrl_pkg::DEF_DATA_BITS
);

  logic                 cpu_req;
  logic [DATA_BITS-1:0] cpu_data;
  logic                 cpu_ack;
  logic                 sw_req;
  logic [DATA_BITS-1:0] sw_data;
  logic                 sw_ack;
  logic                 p2s_start;
  logic [DATA_BITS-1:0] p2s_data;
  logic                 p2s_en;
  logic                 busy;
  logic [DATA_BITS-1:0] cur_data;
  logic                 timeout_err;

  modport slave (
    input  cpu_req, cpu_data, sw_req, sw_data, p2s_en,
    output cpu_ack, sw_ack, p2s_start, p2s_data, busy, cur_data, timeout_err
  );

  modport master (
    output cpu_req, cpu_data, sw_req, sw_data, p2s_en,
    input  cpu_ack, sw_ack, p2s_start, p2s_data, busy, cur_data, timeout_err
  );

endinterface

// File: rtl/led_update_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester wins outright; on a
// tie the requester not granted last wins. The last-grant register only
// moves when the caller enables the grant and someone actually wins.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic i_req_cpu,
  input  logic i_req_sw,
  input  logic i_grant_en,
  output logic o_gnt_cpu,
  output logic o_gnt_sw
);

  // 1 = switch mirror was granted last, so the CPU wins the next tie
  logic r_last_sw;

  assign o_gnt_cpu = i_req_cpu & (~i_req_sw | r_last_sw);
  assign o_gnt_sw  = i_req_sw  & (~i_req_cpu | ~r_last_sw);

  // Remember who was granted last; reset favours the CPU on the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_sw <= 1'b1;
    end else if (i_grant_en && (o_gnt_cpu || o_gnt_sw)) begin
      r_last_sw <= o_gnt_sw;
    end
  end

endmodule

// File: rtl/led_update_ctrl.sv
// Sequencing/arbitration controller for the serial LED shifter.
// Grants CPU or switch-mirror updates round-robin, holds the shifter's
// parallel word, fires a one-cycle start pulse and waits for the shifter's
// completion edge with a timeout.
// Optional feature: define LED_REFRESH_EN to re-send cur_data after
// REFRESH_CYCLES idle cycles with no external request.
module led_update_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int REFRESH_CYCLES = 1_000_000
) (
  input logic              clk,
  input logic              rst,
  led_update_ctrl_if.slave bus
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Reject parameter values the counters cannot represent
  if (TIMEOUT_CYCLES < 2 || REFRESH_CYCLES < 2) begin : g_bad_param
    $error("led_update_ctrl: TIMEOUT_CYCLES and REFRESH_CYCLES must be >= 2");
  end

  state_e               r_state;
  req_id_e              r_winner;
  logic                 r_cpu_ack;
  logic                 r_sw_ack;
  logic                 r_p2s_start;
  logic [DATA_BITS-1:0] r_p2s_data;
  logic                 r_busy;
  logic [DATA_BITS-1:0] r_cur_data;
  logic                 r_timeout_err;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic                 r_p2s_en_q;

  logic                 w_any_req;
  logic                 w_grant_en;
  logic                 w_gnt_cpu;
  logic                 w_gnt_sw;
  logic                 w_rise;
  logic                 w_tmo_hit;
  logic                 w_refresh_hit;
  logic [DATA_BITS-1:0] w_sel_data;

  assign w_any_req  = bus.cpu_req | bus.sw_req;
  assign w_grant_en = (r_state == IDLE);
  // Edge detector: the registered copy is refreshed every cycle, so a rise
  // that happens during FIRE is already "old" by the first WAIT cycle.
  assign w_rise     = bus.p2s_en & ~r_p2s_en_q;
  assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req_cpu  (bus.cpu_req),
    .i_req_sw   (bus.sw_req),
    .i_grant_en (w_grant_en),
    .o_gnt_cpu  (w_gnt_cpu),
    .o_gnt_sw   (w_gnt_sw)
  );

`ifdef LED_REFRESH_EN
  localparam int IDLE_W = $clog2(REFRESH_CYCLES);

  logic [IDLE_W-1:0] r_idle_cnt;

  assign w_refresh_hit = (r_idle_cnt == IDLE_W'(REFRESH_CYCLES - 1));

  // Count consecutive idle cycles; any departure from IDLE restarts it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (r_state == IDLE && !w_any_req && !w_refresh_hit) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end else begin
      r_idle_cnt <= '0;
    end
  end
`else
  assign w_refresh_hit = 1'b0;
`endif

  // Word to load into the shifter: the granted requester, or a re-send
  always_comb begin
    w_sel_data = r_cur_data;
    case (r_winner)
      REQ_CPU: w_sel_data = bus.cpu_data;
      REQ_SW:  w_sel_data = bus.sw_data;
      default: w_sel_data = r_cur_data;
    endcase
  end

  // Main sequencer: IDLE -> LOAD -> FIRE -> WAIT -> IDLE, registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_winner      <= REQ_CPU;
      r_cpu_ack     <= 1'b0;
      r_sw_ack      <= 1'b0;
      r_p2s_start   <= 1'b0;
      r_p2s_data    <= '0;
      r_busy        <= 1'b0;
      r_cur_data    <= '0;
      r_timeout_err <= 1'b0;
      r_tmo_cnt     <= '0;
      r_p2s_en_q    <= 1'b0;
    end else begin
      r_p2s_en_q <= bus.p2s_en;
      case (r_state)
        IDLE: begin
          // Grant decided here so the ack is visible during LOAD
          if (w_any_req) begin
            r_state   <= LOAD;
            r_busy    <= 1'b1;
            r_cpu_ack <= w_gnt_cpu;
            r_sw_ack  <= w_gnt_sw;
            r_winner  <= w_gnt_sw ? REQ_SW : REQ_CPU;
          end else if (w_refresh_hit) begin
            r_state  <= LOAD;
            r_busy   <= 1'b1;
            r_winner <= REQ_REFRESH;
          end
        end
        LOAD: begin
          // Requester still holds data during its ack cycle
          r_cpu_ack   <= 1'b0;
          r_sw_ack    <= 1'b0;
          r_p2s_data  <= w_sel_data;
          r_p2s_start <= 1'b1;
          r_state     <= FIRE;
        end
        FIRE: begin
          r_p2s_start <= 1'b0;
          r_tmo_cnt   <= '0;
          r_state     <= WAIT;
        end
        WAIT: begin
          // Completion is checked first so it wins over the terminal count
          if (w_rise) begin
            r_cur_data <= r_p2s_data;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cpu_ack     = r_cpu_ack;
  assign bus.sw_ack      = r_sw_ack;
  assign bus.p2s_start   = r_p2s_start;
  assign bus.p2s_data    = r_p2s_data;
  assign bus.busy        = r_busy;
  assign bus.cur_data    = r_cur_data;
  assign bus.timeout_err = r_timeout_err;

endmodule
